// File: rtl/prog_loader_pkg.sv
// Shared state encodings and frame constants for the serial program loader.
package prog_loader_pkg;

    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: double-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);

    rx_state_t     state, state_next;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx_s2) state_next = RX_START;
            // A start bit that is high again at its midpoint was a glitch.
            RX_START: if (baud_cnt == HALF_LAST) state_next = rx_s2 ? RX_IDLE : RX_BITS;
            RX_BITS:  if (baud_cnt == FULL_LAST && bit_cnt == 3'(BITS_PER_BYTE - 1))
                          state_next = RX_STOP;
            RX_STOP:  if (baud_cnt == FULL_LAST) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state != state_next || baud_cnt == FULL_LAST) baud_cnt <= '0;
            else                                              baud_cnt <= baud_cnt + 1'b1;
            case (state)
                RX_BITS: if (baud_cnt == FULL_LAST) begin
                    shreg   <= {rx_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                RX_STOP: if (baud_cnt == FULL_LAST) begin
                    if (rx_s2) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shreg;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: UART image -> instruction-memory writes, holds the core until done.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    localparam int unsigned BUF_W    = BITS_PER_BYTE * (BYTES_PER_WORD - 1);
    localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state, state_next;
    logic              byte_valid, frame_err;
    logic [7:0]        byte_data;
    logic [7:0]        cnt_lo;
    logic [15:0]       n_words, word_cnt, word_cnt_inc;
    logic [1:0]        byte_idx;
    logic [BUF_W-1:0]  word_buf;
    logic [ADDR_W-1:0] addr_next;
    logic              write_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= CNT_LO;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        write_word   = 1'b0;
        word_cnt_inc = word_cnt + 16'd1;
        case (state)
            CNT_LO: if (frame_err) state_next = ERR;
                    else if (byte_valid) state_next = CNT_HI;
            CNT_HI: if (frame_err) state_next = ERR;
                    else if (byte_valid)
                        state_next = ({byte_data, cnt_lo} == 16'd0) ? AFTER_DATA : DATA;
            DATA:   if (frame_err) state_next = ERR;
                    else if (byte_valid && byte_idx == LAST_IDX) begin
                        write_word = 1'b1;
                        if (word_cnt_inc == n_words) state_next = AFTER_DATA;
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:    if (frame_err) state_next = ERR;
                    else if (byte_valid) state_next = (byte_data == csum) ? DONE : ERR;
`endif
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cnt_lo    <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            addr_next <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            im_we <= write_word;
            if (byte_valid) begin
                case (state)
                    CNT_LO: cnt_lo  <= byte_data;
                    CNT_HI: n_words <= {byte_data, cnt_lo};
                    DATA: begin
                        byte_idx <= byte_idx + 1'b1;
                        // First byte of a word ends up in the lowest lane.
                        word_buf <= {byte_data, word_buf[BUF_W-1:BITS_PER_BYTE]};
                    end
                    default: ;
                endcase
`ifdef PROG_LOADER_CHECKSUM_EN
                if (state inside {CNT_LO, CNT_HI, DATA}) csum <= csum ^ byte_data;
`endif
            end
            if (write_word) begin
                im_wdata  <= {byte_data, word_buf};
                im_addr   <= addr_next;
                addr_next <= addr_next + ADDR_W'(4);
                word_cnt  <= word_cnt_inc;
            end
        end
    end

    assign cpu_run = (state == DONE);
    assign err     = (state == ERR);
    assign busy    = (state inside {CNT_HI, DATA, CHK});

endmodule
